// File: rtl/unary_dot_mac.sv
// unary_dot_mac
// Serial unary dot-product engine with bias and saturation.
// Consumes TERMS frames of U = 2^BIN_BITS accepted bits each, where every
// frame carries two unary operands (a, b). Frame 0 also carries a unary
// bias (c). The block accumulates
//   R = min(U, c + sum floor(a*b/U)).
// It then replays R as a unary frame on out, with out_valid high for U cycles.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      begin a new dot product (honoured only while idle)
//   clear      synchronous abort back to idle, highest priority
//   in_valid   a/b/c carry a bit this cycle
//   in_ready   block is accumulating and will take a/b/c bits
//   a, b       serial unary operands
//   c          serial unary bias (counted during frame 0 only)
//   out        serial unary result
//   out_valid  out is meaningful
//   done       one-cycle pulse after the last result bit
//   result     binary result R, held until the next start
//   sat        sticky flag: some accumulation exceeded U and was clamped
module unary_dot_mac #(
  parameter int BIN_BITS = 4,
  parameter int TERMS    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                a,
  input  logic                b,
  input  logic                c,
  output logic                out,
  output logic                out_valid,
  output logic                done,
  output logic [BIN_BITS:0]   result,
  output logic                sat
);

  localparam int U  = 1 << BIN_BITS;
  localparam int CW = BIN_BITS + 1;          // counts hold 0..U
  localparam int PW = 2 * BIN_BITS + 2;      // full product width
  localparam int TW = (TERMS > 1) ? $clog2(TERMS) : 1;

  localparam logic [CW-1:0]       LAST_BIT  = CW'(U - 1);
  localparam logic [CW-1:0]       U_CLAMP   = CW'(U);
  localparam logic [PW-1:0]       U_WIDE    = PW'(U);
  localparam logic [TW-1:0]       LAST_TERM = TW'(TERMS - 1);
  localparam logic [BIN_BITS-1:0] LAST_EMIT = BIN_BITS'(U - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]       bit_cnt;
  logic [TW-1:0]       term_cnt;
  logic [CW-1:0]       cnt_a, cnt_b, cnt_c;
  logic [CW-1:0]       acc;
  logic [BIN_BITS-1:0] emit_cnt;

  logic          accept;
  logic          frame_end;
  logic          first_term;
  logic          last_term;
  logic [CW-1:0] a_tot, b_tot, c_tot;
  logic [PW-1:0] prod;
  logic [PW-1:0] sum;
  logic          over;
  logic [CW-1:0] acc_new;

  assign accept     = in_valid && (state == ACCUM);
  assign frame_end  = accept && (bit_cnt == LAST_BIT);
  assign first_term = (term_cnt == TW'(0));
  assign last_term  = (term_cnt == LAST_TERM);

  // Popcounts including the bit being accepted this cycle, so the closing
  // bit of a frame contributes to its own product.
  assign a_tot = cnt_a + CW'(a);
  assign b_tot = cnt_b + CW'(b);
  assign c_tot = cnt_c + CW'(c && first_term);

  // Full-width product, then divide by U. The sum stays wide so that an
  // overflow past U is always visible to the clamp.
  assign prod    = PW'(a_tot) * PW'(b_tot);
  assign sum     = PW'(first_term ? c_tot : acc) + (prod >> BIN_BITS);
  assign over    = (sum > U_WIDE);
  assign acc_new = over ? U_CLAMP : sum[CW-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (frame_end && last_term) state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        // Ones first, then zeros: first R of the U cycles are high.
        out       = ({1'b0, emit_cnt} < result);
        if (emit_cnt == LAST_EMIT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      term_cnt <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      cnt_c    <= '0;
      acc      <= '0;
      emit_cnt <= '0;
      result   <= '0;
      sat      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // clear only aborts the sequence; result and sat are kept.
      if (!clear) begin
        case (state)
          IDLE: begin
            if (start) begin
              bit_cnt  <= '0;
              term_cnt <= '0;
              cnt_a    <= '0;
              cnt_b    <= '0;
              cnt_c    <= '0;
              acc      <= '0;
              emit_cnt <= '0;
              result   <= '0;
              sat      <= 1'b0;
            end
          end
          ACCUM: begin
            if (frame_end) begin
              bit_cnt  <= '0;
              cnt_a    <= '0;
              cnt_b    <= '0;
              cnt_c    <= '0;
              acc      <= acc_new;
              term_cnt <= term_cnt + TW'(1);
              if (over) sat <= 1'b1;
              if (last_term) begin
                result   <= acc_new;
                emit_cnt <= '0;
              end
            end else if (accept) begin
              bit_cnt <= bit_cnt + CW'(1);
              cnt_a   <= a_tot;
              cnt_b   <= b_tot;
              cnt_c   <= c_tot;
            end
          end
          EMIT: begin
            emit_cnt <= emit_cnt + BIN_BITS'(1);
            if (emit_cnt == LAST_EMIT) done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unary_dot_mac.sv
// Directed testbench for unary_dot_mac (BIN_BITS=4, U=16, TERMS=4).
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_unary_dot_mac;

  localparam int BB = 4;
  localparam int T  = 4;
  localparam int U  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, clear, in_valid;
  logic        a, b, c;
  logic        in_ready, out, out_valid, done, sat;
  logic [BB:0] result;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  unary_dot_mac #(.BIN_BITS(BB), .TERMS(T)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .out      (out),
    .out_valid(out_valid),
    .done     (done),
    .result   (result),
    .sat      (sat)
  );

  // Pulse start for one cycle. in_valid and operands are high in that cycle
  // and must be ignored because the block is still idle.
  task automatic do_start();
    start = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; c = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  // One frame of U accepted bits carrying na/nb/nc ones. With scramble the
  // ones are spread by a fixed permutation. With bubbles, random idle cycles
  // carrying garbage operands are inserted.
  task automatic send_frame(input int na, input int nb, input int nc,
                            input bit scramble, input bit bubbles);
    int pa, pb, pc;
    for (int i = 0; i < U; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
          @(negedge clk);
        end
      end
      pa = scramble ? (i * 5 + 3) % U : i;
      pb = scramble ? (i * 7 + 1) % U : i;
      pc = scramble ? (i * 3) % U : i;
      in_valid = 1'b1;
      a = (pa < na); b = (pb < nb); c = (pc < nc);
      @(negedge clk);
    end
  endtask

  // Full dot product: frame 0 uses (f0a,f0b,f0c). Frames 1..T-1 use
  // (fa,fb) with c held high; c must be ignored after frame 0.
  task automatic run_dot(input int f0a, input int f0b, input int f0c,
                         input int fa, input int fb,
                         input bit scramble, input bit bubbles);
    do_start();
    send_frame(f0a, f0b, f0c, scramble, bubbles);
    for (int t = 1; t < T; t++) send_frame(fa, fb, U, scramble, bubbles);
    in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out, out_valid, done, sat} !== 5'b0) begin
      $display("FAIL reset_outputs: got %b expected 00000",
               {in_ready, out, out_valid, done, sat});
    end else passed++;
    checks++;
    if (result !== 5'd0) $display("FAIL reset_result: got %0d expected 0", result);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_idle: in_ready got %b expected 0", in_ready);
    else passed++;
    $display("test_reset: done");
  endtask

  task automatic test_saturate();
    logic [1:0] expv;
    run_dot(16, 16, 0, 16, 16, 1'b0, 1'b0);
    checks++;
    if (result !== 5'd16) $display("FAIL sat_result: got %0d expected 16", result);
    else passed++;
    checks++;
    if (sat !== 1'b1) $display("FAIL sat_flag: got %b expected 1", sat);
    else passed++;
    for (int i = 0; i < U; i++) begin
      expv = {1'b1, 1'b1};
      checks++;
      if ({out_valid, out} !== expv)
        $display("FAIL sat_emit[%0d]: got %b expected %b", i, {out_valid, out}, expv);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid, in_ready} !== 3'b100)
      $display("FAIL sat_done: got %b expected 100", {done, out_valid, in_ready});
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL sat_done_pulse: got %b expected 0", done);
    else passed++;
    $display("test_saturate: result=%0d sat=%b", result, sat);
  endtask

  task automatic test_bias();
    logic [1:0] expv;
    do_start();
    checks++;
    if (in_ready !== 1'b1) $display("FAIL bias_in_ready: got %b expected 1", in_ready);
    else passed++;
    send_frame(8, 8, 3, 1'b0, 1'b0);
    for (int t = 1; t < T; t++) send_frame(0, 16, U, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (result !== 5'd7) $display("FAIL bias_result: got %0d expected 7", result);
    else passed++;
    checks++;
    if (sat !== 1'b0) $display("FAIL bias_sat: got %b expected 0", sat);
    else passed++;
    for (int i = 0; i < U; i++) begin
      expv = {1'b1, (i < 7)};
      checks++;
      if ({out_valid, out} !== expv)
        $display("FAIL bias_emit[%0d]: got %b expected %b", i, {out_valid, out}, expv);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid} !== 2'b10)
      $display("FAIL bias_done: got %b expected 10", {done, out_valid});
    else passed++;
    @(negedge clk);
    $display("test_bias: result=%0d sat=%b", result, sat);
  endtask

  task automatic test_floor();
    logic [1:0] expv;
    run_dot(15, 15, 0, 0, 15, 1'b0, 1'b0);
    checks++;
    if (result !== 5'd14) $display("FAIL floor_result: got %0d expected 14", result);
    else passed++;
    for (int i = 0; i < U; i++) begin
      expv = {1'b1, (i < 14)};
      checks++;
      if ({out_valid, out} !== expv)
        $display("FAIL floor_emit[%0d]: got %b expected %b", i, {out_valid, out}, expv);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) $display("FAIL floor_done: got %b expected 1", done);
    else passed++;
    @(negedge clk);
    $display("test_floor: result=14 case complete");

    run_dot(1, 15, 0, 1, 15, 1'b0, 1'b0);
    checks++;
    if (result !== 5'd0) $display("FAIL zero_result: got %0d expected 0", result);
    else passed++;
    for (int i = 0; i < U; i++) begin
      expv = {1'b1, 1'b0};
      checks++;
      if ({out_valid, out} !== expv)
        $display("FAIL zero_emit[%0d]: got %b expected %b", i, {out_valid, out}, expv);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid} !== 2'b10)
      $display("FAIL zero_done: got %b expected 10", {done, out_valid});
    else passed++;
    @(negedge clk);
    $display("test_floor: result=0 case complete");
  endtask

  task automatic test_bubbles();
    logic [1:0] expv;
    run_dot(8, 8, 3, 0, 16, 1'b1, 1'b1);
    checks++;
    if (result !== 5'd7) $display("FAIL bub_result: got %0d expected 7", result);
    else passed++;
    checks++;
    if (sat !== 1'b0) $display("FAIL bub_sat: got %b expected 0", sat);
    else passed++;
    for (int i = 0; i < U; i++) begin
      expv = {1'b1, (i < 7)};
      checks++;
      if ({out_valid, out} !== expv)
        $display("FAIL bub_emit[%0d]: got %b expected %b", i, {out_valid, out}, expv);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid} !== 2'b10)
      $display("FAIL bub_done: got %b expected 10", {done, out_valid});
    else passed++;
    @(negedge clk);
    $display("test_bubbles: result=%0d", result);
  endtask

  task automatic test_clear();
    logic [1:0] expv;
    bit seen_done;
    do_start();
    send_frame(8, 8, 3, 1'b0, 1'b0);
    start = 1'b1;                       // held through frame 1, must be ignored
    send_frame(0, 16, U, 1'b0, 1'b0);
    start = 1'b0;
    for (int t = 2; t < T; t++) send_frame(0, 16, U, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expv = {1'b1, (i < 7)};
      checks++;
      if ({out_valid, out} !== expv)
        $display("FAIL clr_emit[%0d]: got %b expected %b", i, {out_valid, out}, expv);
      else passed++;
      start = (i == 1);                 // start during emit must be ignored
      clear = (i == 4);
      @(negedge clk);
    end
    start = 1'b0; clear = 1'b0;
    checks++;
    if ({out_valid, out, in_ready, done} !== 4'b0)
      $display("FAIL clr_outputs: got %b expected 0000", {out_valid, out, in_ready, done});
    else passed++;
    checks++;
    if (result !== 5'd7) $display("FAIL clr_result: got %0d expected 7", result);
    else passed++;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || out_valid || in_ready) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_done !== 1'b0) $display("FAIL clr_stays_idle: activity got 1 expected 0");
    else passed++;
    $display("test_clear: result=%0d held", result);
  endtask

  task automatic test_reset_mid();
    logic [1:0] expv;
    do_start();
    send_frame(8, 8, 3, 1'b0, 1'b0);
    send_frame(0, 16, U, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 1'b1; b = 1'b1; c = 1'b1;
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out, done, sat} !== 5'b0)
      $display("FAIL rstmid_outputs: got %b expected 00000",
               {in_ready, out_valid, out, done, sat});
    else passed++;
    checks++;
    if (result !== 5'd0) $display("FAIL rstmid_result: got %0d expected 0", result);
    else passed++;
    in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL rstmid_idle: in_ready got %b expected 0", in_ready);
    else passed++;
    run_dot(8, 8, 3, 0, 16, 1'b0, 1'b0);
    checks++;
    if (result !== 5'd7) $display("FAIL rstmid_result2: got %0d expected 7", result);
    else passed++;
    for (int i = 0; i < U; i++) begin
      expv = {1'b1, (i < 7)};
      checks++;
      if ({out_valid, out} !== expv)
        $display("FAIL rstmid_emit[%0d]: got %b expected %b", i, {out_valid, out}, expv);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) $display("FAIL rstmid_done: got %b expected 1", done);
    else passed++;
    @(negedge clk);
    $display("test_reset_mid: result=%0d", result);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_saturate();
    test_bias();
    test_floor();
    test_bubbles();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
